// File: rtl/butterfly_lsu.sv
// butterfly_lsu: MEM-stage load/store unit with byte-lane steering,
// sign/zero extension, alignment checking and a bus timeout.
module butterfly_lsu #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [XLEN-1:0]   req_addr_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    input  logic [4:0]        req_rd_i,
    output logic              rsp_valid_o,
    output logic [XLEN-1:0]   rsp_rdata_o,
    output logic [4:0]        rsp_rd_o,
    output logic              rsp_we_o,
    output logic              rsp_err_o,
    output logic [1:0]        rsp_err_code_o,
    output logic              busy_o,
    output logic              dmem_valid_o,
    output logic              dmem_we_o,
    output logic [XLEN-1:0]   dmem_addr_o,
    output logic [XLEN-1:0]   dmem_wdata_o,
    output logic [XLEN/8-1:0] dmem_wstrb_o,
    input  logic [XLEN-1:0]   dmem_rdata_i,
    input  logic              dmem_ready_i
);

    localparam int NB = XLEN / 8;
    localparam int LW = $clog2(NB);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [TW-1:0] TMO_LAST =
        TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_TMO   = 2'b10;
    localparam logic [1:0] ERR_SIZE  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef struct packed {
        logic          we;
        logic [1:0]    size;
        logic          uns;
        logic [LW-1:0] off;
        logic [4:0]    rd;
    } req_t;

    state_t          state_q;
    state_t          state_d;
    req_t            req_q;
    req_t            req_d;
    logic [TW-1:0]   cnt_q;
    logic [TW-1:0]   cnt_d;

    logic            dv_q;
    logic            dv_d;
    logic            dwe_q;
    logic            dwe_d;
    logic [XLEN-1:0] daddr_q;
    logic [XLEN-1:0] daddr_d;
    logic [XLEN-1:0] dwdata_q;
    logic [XLEN-1:0] dwdata_d;
    logic [NB-1:0]   dstrb_q;
    logic [NB-1:0]   dstrb_d;

    logic            rv_q;
    logic            rv_d;
    logic [XLEN-1:0] rdata_q;
    logic [XLEN-1:0] rdata_d;
    logic [4:0]      rrd_q;
    logic [4:0]      rrd_d;
    logic            rwe_q;
    logic            rwe_d;
    logic            rerr_q;
    logic            rerr_d;
    logic [1:0]      rcode_q;
    logic [1:0]      rcode_d;

    logic [LW-1:0]   in_off;
    logic [NB-1:0]   size_strb;
    logic [NB-1:0]   strb_sh;
    logic [XLEN-1:0] wdata_sh;
    logic            misaligned;
    logic            illegal;

    logic [XLEN-1:0] rd_sh;
    logic [XLEN-1:0] ext_mask;
    logic [XLEN-1:0] rd_ext;
    logic            sgn;

    // Request-side decode works on the raw inputs so the bus
    // registers can be loaded on the accepting edge.
    always_comb begin
        in_off    = req_addr_i[LW-1:0];
        size_strb = '0;
        unique case (req_size_i)
            2'b00: size_strb = NB'(8'h01);
            2'b01: size_strb = NB'(8'h03);
            2'b10: size_strb = NB'(8'h0F);
            2'b11: size_strb = NB'(8'hFF);
            default: size_strb = '0;
        endcase
        strb_sh  = size_strb << in_off;
        wdata_sh = req_wdata_i << {in_off, 3'b000};
        illegal  = (XLEN == 32) && (req_size_i == 2'b11);
        misaligned =
            ((req_size_i == 2'b01) && req_addr_i[0]) ||
            ((req_size_i == 2'b10) && (|req_addr_i[1:0])) ||
            ((req_size_i == 2'b11) && (|req_addr_i[2:0]));
    end

    always_comb begin
        rd_sh    = dmem_rdata_i >> {req_q.off, 3'b000};
        ext_mask = '1;
        sgn      = 1'b0;
        unique case (req_q.size)
            2'b00: begin
                ext_mask = XLEN'(8'hFF);
                sgn      = rd_sh[7];
            end
            2'b01: begin
                ext_mask = XLEN'(16'hFFFF);
                sgn      = rd_sh[15];
            end
            2'b10: begin
                ext_mask = XLEN'(32'hFFFF_FFFF);
                sgn      = rd_sh[31];
            end
            default: begin
                ext_mask = '1;
                sgn      = 1'b0;
            end
        endcase
        if (sgn && !req_q.uns) begin
            rd_ext = rd_sh | ~ext_mask;
        end else begin
            rd_ext = rd_sh & ext_mask;
        end
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        cnt_d    = cnt_q;
        dv_d     = dv_q;
        dwe_d    = dwe_q;
        daddr_d  = daddr_q;
        dwdata_d = dwdata_q;
        dstrb_d  = dstrb_q;
        rv_d     = 1'b0;
        rdata_d  = '0;
        rrd_d    = '0;
        rwe_d    = 1'b0;
        rerr_d   = 1'b0;
        rcode_d  = ERR_NONE;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    req_d.we   = req_we_i;
                    req_d.size = req_size_i;
                    req_d.uns  = req_unsigned_i;
                    req_d.off  = in_off;
                    req_d.rd   = req_rd_i;
                    cnt_d      = '0;
                    if (illegal || misaligned) begin
                        state_d = RESP;
                        rv_d    = 1'b1;
                        rrd_d   = req_rd_i;
                        rerr_d  = 1'b1;
                        rcode_d = illegal ? ERR_SIZE : ERR_ALIGN;
                    end else begin
                        state_d  = ACCESS;
                        dv_d     = 1'b1;
                        dwe_d    = req_we_i;
                        daddr_d  = {req_addr_i[XLEN-1:LW], LW'(0)};
                        dwdata_d = wdata_sh;
                        dstrb_d  = req_we_i ? strb_sh : '0;
                    end
                end
            end
            ACCESS: begin
                // Ready is tested first so it wins over a coinciding timeout.
                if (dmem_ready_i || (TMO_EN && cnt_q == TMO_LAST)) begin
                    state_d  = RESP;
                    cnt_d    = '0;
                    dv_d     = 1'b0;
                    dwe_d    = 1'b0;
                    daddr_d  = '0;
                    dwdata_d = '0;
                    dstrb_d  = '0;
                    rv_d     = 1'b1;
                    rrd_d    = req_q.rd;
                    if (dmem_ready_i) begin
                        rwe_d   = !req_q.we && (req_q.rd != 5'd0);
                        rdata_d = req_q.we ? '0 : rd_ext;
                    end else begin
                        rerr_d  = 1'b1;
                        rcode_d = ERR_TMO;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            req_q    <= '0;
            cnt_q    <= '0;
            dv_q     <= 1'b0;
            dwe_q    <= 1'b0;
            daddr_q  <= '0;
            dwdata_q <= '0;
            dstrb_q  <= '0;
            rv_q     <= 1'b0;
            rdata_q  <= '0;
            rrd_q    <= '0;
            rwe_q    <= 1'b0;
            rerr_q   <= 1'b0;
            rcode_q  <= ERR_NONE;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            cnt_q    <= cnt_d;
            dv_q     <= dv_d;
            dwe_q    <= dwe_d;
            daddr_q  <= daddr_d;
            dwdata_q <= dwdata_d;
            dstrb_q  <= dstrb_d;
            rv_q     <= rv_d;
            rdata_q  <= rdata_d;
            rrd_q    <= rrd_d;
            rwe_q    <= rwe_d;
            rerr_q   <= rerr_d;
            rcode_q  <= rcode_d;
        end
    end

    assign req_ready_o    = (state_q == IDLE);
    assign busy_o         = (state_q != IDLE) || req_valid_i;
    assign dmem_valid_o   = dv_q;
    assign dmem_we_o      = dwe_q;
    assign dmem_addr_o    = daddr_q;
    assign dmem_wdata_o   = dwdata_q;
    assign dmem_wstrb_o   = dstrb_q;
    assign rsp_valid_o    = rv_q;
    assign rsp_rdata_o    = rdata_q;
    assign rsp_rd_o       = rrd_q;
    assign rsp_we_o       = rwe_q;
    assign rsp_err_o      = rerr_q;
    assign rsp_err_code_o = rcode_q;

endmodule

// File: tb/tb_butterfly_lsu.sv
// tb_butterfly_lsu: directed and random checks of butterfly_lsu
// against a byte-level reference model (XLEN=32/T=4 and XLEN=64/T=16).
module tb_butterfly_lsu;

    localparam int T32 = 4;
    localparam int T64 = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v32 = 1'b0;
    logic        v64 = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        uns = 1'b0;
    logic [63:0] addr = '0;
    logic [63:0] wdata = '0;
    logic [4:0]  rd = '0;
    logic [63:0] rdata = '0;
    logic        rdy32 = 1'b0;
    logic        rdy64 = 1'b0;

    logic        a_ready, a_rv, a_rwe, a_err, a_busy, a_dv, a_dwe;
    logic [31:0] a_rdata, a_daddr, a_dwdata;
    logic [4:0]  a_rd;
    logic [1:0]  a_code;
    logic [3:0]  a_strb;

    logic        b_ready, b_rv, b_rwe, b_err, b_busy, b_dv, b_dwe;
    logic [63:0] b_rdata, b_daddr, b_dwdata;
    logic [4:0]  b_rd;
    logic [1:0]  b_code;
    logic [7:0]  b_strb;

    int n_tests = 0;
    int n_fail  = 0;
    string ctx = "reset";

    typedef struct {
        logic        ready, busy, rv, rwe, err, dv, dwe;
        logic [1:0]  code;
        logic [4:0]  rd;
        logic [63:0] rdata, daddr, dwdata;
        logic [7:0]  strb;
    } obs_t;

    butterfly_lsu #(.XLEN(32), .TIMEOUT_CYCLES(T32)) u32 (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(v32), .req_ready_o(a_ready),
        .req_we_i(we), .req_size_i(size), .req_unsigned_i(uns),
        .req_addr_i(addr[31:0]), .req_wdata_i(wdata[31:0]),
        .req_rd_i(rd),
        .rsp_valid_o(a_rv), .rsp_rdata_o(a_rdata), .rsp_rd_o(a_rd),
        .rsp_we_o(a_rwe), .rsp_err_o(a_err), .rsp_err_code_o(a_code),
        .busy_o(a_busy),
        .dmem_valid_o(a_dv), .dmem_we_o(a_dwe), .dmem_addr_o(a_daddr),
        .dmem_wdata_o(a_dwdata), .dmem_wstrb_o(a_strb),
        .dmem_rdata_i(rdata[31:0]), .dmem_ready_i(rdy32)
    );

    butterfly_lsu #(.XLEN(64), .TIMEOUT_CYCLES(T64)) u64 (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(v64), .req_ready_o(b_ready),
        .req_we_i(we), .req_size_i(size), .req_unsigned_i(uns),
        .req_addr_i(addr), .req_wdata_i(wdata),
        .req_rd_i(rd),
        .rsp_valid_o(b_rv), .rsp_rdata_o(b_rdata), .rsp_rd_o(b_rd),
        .rsp_we_o(b_rwe), .rsp_err_o(b_err), .rsp_err_code_o(b_code),
        .busy_o(b_busy),
        .dmem_valid_o(b_dv), .dmem_we_o(b_dwe), .dmem_addr_o(b_daddr),
        .dmem_wdata_o(b_dwdata), .dmem_wstrb_o(b_strb),
        .dmem_rdata_i(rdata), .dmem_ready_i(rdy64)
    );

    always #5 clk = ~clk;

    function automatic obs_t get_obs(input bit is64);
        obs_t o;
        if (is64) begin
            o.ready = b_ready; o.busy = b_busy; o.rv = b_rv;
            o.rwe = b_rwe; o.err = b_err; o.dv = b_dv; o.dwe = b_dwe;
            o.code = b_code; o.rd = b_rd; o.rdata = b_rdata;
            o.daddr = b_daddr; o.dwdata = b_dwdata; o.strb = b_strb;
        end else begin
            o.ready = a_ready; o.busy = a_busy; o.rv = a_rv;
            o.rwe = a_rwe; o.err = a_err; o.dv = a_dv; o.dwe = a_dwe;
            o.code = a_code; o.rd = a_rd; o.rdata = {32'h0, a_rdata};
            o.daddr = {32'h0, a_daddr}; o.dwdata = {32'h0, a_dwdata};
            o.strb = {4'h0, a_strb};
        end
        return o;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: got %h expected %h", ctx, tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input bit is64);
        obs_t o;
        o = get_obs(is64);
        chk("idle.ready", 64'(o.ready), 64'd1);
        chk("idle.busy", 64'(o.busy), 64'd0);
        chk("idle.rv", 64'(o.rv), 64'd0);
        chk("idle.rwe", 64'(o.rwe), 64'd0);
        chk("idle.err", 64'(o.err), 64'd0);
        chk("idle.rdata", o.rdata, 64'd0);
        chk("idle.dv", 64'(o.dv), 64'd0);
        chk("idle.dwe", 64'(o.dwe), 64'd0);
        chk("idle.daddr", o.daddr, 64'd0);
        chk("idle.dwdata", o.dwdata, 64'd0);
        chk("idle.strb", 64'(o.strb), 64'd0);
    endtask

    // dly = ACCESS cycles with ready low before ready rises; -1 = never.
    task automatic txn(input bit is64, input logic w, input logic [1:0] sz,
                       input logic u, input logic [63:0] a,
                       input logic [63:0] wd, input logic [4:0] r,
                       input int dly, input logic [63:0] rdt);
        obs_t o;
        int nb, bytes, off, tmo, n;
        bit ill, early, timed;
        logic [63:0] xm, bm, e_addr, e_wd, e_rdata, sh;
        logic [7:0] e_strb;
        nb    = is64 ? 8 : 4;
        tmo   = is64 ? T64 : T32;
        xm    = is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
        bytes = 1 << sz;
        off   = int'(a[2:0]) % nb;
        ill   = !is64 && (sz == 2'b11);
        early = ill || ((int'(a[2:0]) % bytes) != 0);
        timed = !early && (dly < 0 || dly >= tmo);
        n     = timed ? tmo : dly + 1;
        e_addr = (a & xm) - 64'(off);
        e_wd   = (wd << (8 * off)) & xm;
        e_strb = w ? 8'((((1 << bytes) - 1) << off) & 255) : 8'h00;
        bm = (bytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF
                          : ((64'd1 << (8 * bytes)) - 64'd1);
        sh = ((rdt & xm) >> (8 * off)) & bm;
        if (!u && sh[8 * bytes - 1]) sh = sh | ~bm;
        e_rdata = (w || timed) ? 64'd0 : (sh & xm);

        o = get_obs(is64);
        chk("c0.ready", 64'(o.ready), 64'd1);
        we = w; size = sz; uns = u; addr = a; wdata = wd; rd = r;
        rdata = rdt;
        if (is64) v64 = 1'b1; else v32 = 1'b1;
        #1;
        o = get_obs(is64);
        chk("c0.busy", 64'(o.busy), 64'd1);
        @(posedge clk); #1;
        v32 = 1'b0; v64 = 1'b0;
        // Scramble the request fields: the unit must work from its copy.
        we = ~w; size = 2'($urandom); uns = ~u;
        addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
        rd = 5'($urandom);
        if (early) begin
            o = get_obs(is64);
            chk("early.dv", 64'(o.dv), 64'd0);
            chk("early.rv", 64'(o.rv), 64'd1);
            chk("early.err", 64'(o.err), 64'd1);
            chk("early.code", 64'(o.code), ill ? 64'd3 : 64'd1);
            chk("early.rwe", 64'(o.rwe), 64'd0);
            chk("early.rdata", o.rdata, 64'd0);
        end else begin
            for (int k = 1; k <= n; k++) begin
                o = get_obs(is64);
                chk("acc.dv", 64'(o.dv), 64'd1);
                chk("acc.dwe", 64'(o.dwe), 64'(w));
                chk("acc.daddr", o.daddr, e_addr);
                chk("acc.dwdata", o.dwdata, e_wd);
                chk("acc.strb", 64'(o.strb), 64'(e_strb));
                chk("acc.rv", 64'(o.rv), 64'd0);
                chk("acc.ready", 64'(o.ready), 64'd0);
                chk("acc.busy", 64'(o.busy), 64'd1);
                if (is64) rdy64 = !timed && (k == n);
                else      rdy32 = !timed && (k == n);
                @(posedge clk); #1;
            end
            rdy32 = 1'b0; rdy64 = 1'b0;
            o = get_obs(is64);
            chk("rsp.dv", 64'(o.dv), 64'd0);
            chk("rsp.rv", 64'(o.rv), 64'd1);
            chk("rsp.err", 64'(o.err), 64'(timed));
            if (timed) chk("rsp.code", 64'(o.code), 64'd2);
            chk("rsp.rdata", o.rdata, e_rdata);
            chk("rsp.rd", 64'(o.rd), 64'(r));
            chk("rsp.rwe", 64'(o.rwe),
                64'(!w && !timed && (r != 5'd0)));
        end
        @(posedge clk); #1;
        o = get_obs(is64);
        chk("end.rv", 64'(o.rv), 64'd0);
        chk("end.ready", 64'(o.ready), 64'd1);
    endtask

    initial begin
        obs_t o;
        logic [63:0] ra;
        logic [1:0]  rs;
        #2;
        chk_idle(1'b0);
        chk_idle(1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        ctx = "post_reset";
        chk_idle(1'b0);
        chk_idle(1'b1);

        ctx = "sw"; txn(0, 1, 2'b10, 0, 64'h100, 64'hDEADBEEF, 5'd0, 0, 64'h0);
        ctx = "sb"; txn(0, 1, 2'b00, 0, 64'h103, 64'hA5, 5'd3, 0, 64'h0);
        ctx = "lb"; txn(0, 0, 2'b00, 0, 64'h103, 64'h0, 5'd4, 0, 64'h80123456);
        ctx = "lbu"; txn(0, 0, 2'b00, 1, 64'h103, 64'h0, 5'd4, 1, 64'h80123456);
        ctx = "lh"; txn(0, 0, 2'b01, 0, 64'h102, 64'h0, 5'd5, 0, 64'h80011234);
        ctx = "lh_x0"; txn(0, 0, 2'b01, 0, 64'h102, 64'h0, 5'd0, 0, 64'h80011234);
        ctx = "lw_mis"; txn(0, 0, 2'b10, 0, 64'h101, 64'h0, 5'd7, 0, 64'h0);
        ctx = "tmo"; txn(0, 0, 2'b10, 0, 64'h200, 64'h0, 5'd9, -1, 64'h1234);
        ctx = "tmo_edge"; txn(0, 0, 2'b10, 0, 64'h200, 64'h0, 5'd9, 3, 64'h1234);
        ctx = "ld64"; txn(1, 0, 2'b11, 0, 64'h8, 64'h0, 5'd1, 0,
                          64'h0123456789ABCDEF);
        ctx = "sw64"; txn(1, 1, 2'b10, 0, 64'h4, 64'hCAFEF00D, 5'd0, 0, 64'h0);
        ctx = "sd64_mis"; txn(1, 1, 2'b11, 0, 64'h4, 64'h1, 5'd0, 0, 64'h0);
        ctx = "ld32_ill"; txn(0, 0, 2'b11, 0, 64'h8, 64'h0, 5'd2, 0, 64'h0);

        for (int i = 0; i < 60; i++) begin
            rs = 2'($urandom);
            ra = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) ra = ra & ~64'((1 << rs) - 1);
            ctx = $sformatf("rand%0d", i);
            txn(i[0], 1'($urandom), rs, 1'($urandom), ra,
                {$urandom, $urandom}, 5'($urandom),
                $urandom_range(0, 5), {$urandom, $urandom});
        end

        ctx = "rst_mid";
        we = 1'b0; size = 2'b11; uns = 1'b0; addr = 64'h40; rd = 5'd6;
        v64 = 1'b1;
        @(posedge clk); #1;
        v64 = 1'b0;
        @(posedge clk); #1;
        o = get_obs(1'b1);
        chk("pre.dv", 64'(o.dv), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_idle(1'b1);
        chk_idle(1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk_idle(1'b1);
        end
        ctx = "after_rst";
        txn(1, 0, 2'b00, 0, 64'h41, 64'h0, 5'd8, 2, 64'h0000_0000_0000_7F00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/butterfly_lsu.md
Name: butterfly_lsu

Overview:
Parametrised load/store unit for the MEM stage. It replaces the store-only memory path with full load and store support: byte, half, word and (XLEN=64) double accesses, byte-lane steering, sign/zero extension, alignment checking and a bus timeout. It sits between the EX/MEM pipeline register and the external data-memory port. It issues a busy stall while a transaction is outstanding.

Parameters:
XLEN, 32, data/address width; legal values 32 or 64.
TIMEOUT_CYCLES, 16, maximum cycles in ACCESS before abort; 0 disables the timeout.
NB (derived), XLEN/8, byte lanes; LW = log2(NB) is the lane-index width.

Ports:
clk_i  in  1  clock, rising edge.
rst_n_i  in  1  asynchronous, active-low reset.
req_valid_i  in  1  request from EX/MEM.
req_ready_o  out  1  unit can accept a request.
req_we_i  in  1  1 = store, 0 = load.
req_size_i  in  2  00 = byte, 01 = half, 10 = word, 11 = double.
req_unsigned_i  in  1  zero-extend load result.
req_addr_i  in  XLEN  byte address.
req_wdata_i  in  XLEN  store data, right-aligned.
req_rd_i  in  5  load destination register.
rsp_valid_o  out  1  one-cycle completion pulse.
rsp_rdata_o  out  XLEN  extended load data.
rsp_rd_o  out  5  destination register.
rsp_we_o  out  1  regfile write enable.
rsp_err_o  out  1  access failed.
rsp_err_code_o  out  2  01 = misaligned, 10 = timeout, 11 = illegal size.
busy_o  out  1  pipeline stall.
dmem_valid_o  out  1  bus request.
dmem_we_o  out  1  bus write.
dmem_addr_o  out  XLEN  bus address, NB-aligned.
dmem_wdata_o  out  XLEN  lane-shifted store data.
dmem_wstrb_o  out  NB  byte strobes.
dmem_rdata_i  in  XLEN  bus read data.
dmem_ready_i  in  1  bus completion.

Behaviour:
- One clock (clk_i). Reset is asynchronous, active-low (rst_n_i).
- Reset values:
  - state = IDLE.
  - All rsp_* outputs, dmem_* outputs, busy_o and the timeout counter are 0.
  - req_ready_o = 1 after reset.
- FSM has three states: IDLE, ACCESS, RESP.
  - req_ready_o = (state == IDLE).
  - busy_o = (state != IDLE) OR (req_valid_i AND state == IDLE).
- IDLE: on req_valid_i, latch all req_* fields.
  - If size 11 with XLEN = 32, go to RESP with error code 11.
  - Else if misaligned (half with addr[0] set; word with addr[1:0] nonzero; double with addr[2:0] nonzero), go to RESP with error code 01. No bus cycle is issued.
  - Otherwise go to ACCESS.
- ACCESS: all dmem_* outputs are registered and held stable until dmem_ready_i.
  - dmem_valid_o = 1.
  - dmem_addr_o = addr with low LW bits cleared.
  - dmem_wstrb_o = size mask (1/3/F/FF) shifted left by addr[LW-1:0]; forced to 0 for loads.
  - dmem_wdata_o = wdata shifted left by 8 × addr[LW-1:0].
  - On dmem_ready_i: shift rdata right by the same lane offset, sign- or zero-extend per size and req_unsigned_i, then go to RESP.
- Timeout: the counter increments each ACCESS cycle without dmem_ready_i.
  - When count == TIMEOUT_CYCLES - 1 and dmem_ready_i = 0, drop dmem_valid_o and go to RESP with error code 10.
  - If dmem_ready_i and the timeout coincide, dmem_ready_i wins and there is no error.
- RESP: rsp_valid_o = 1 for exactly one cycle, then go to IDLE.
  - rsp_we_o = load AND NOT err AND rd != 0.
  - rsp_rdata_o = 0 for stores and for errors.
- Latency: request accepted in cycle 0, dmem_valid_o high in cycle 1. With zero-wait ready, rsp_valid_o is high in cycle 2 and req_ready_o returns in cycle 3.
  - Misaligned or illegal requests respond in cycle 1.
- Only one transaction is outstanding at a time. There is no response back-pressure.
- req_* inputs are ignored outside IDLE.
- Reset asserted mid-ACCESS drops dmem_valid_o immediately (asynchronous). No response is generated.

Test Plan:
1. SW addr 0x100, data 0xDEADBEEF, ready in cycle 1 -> dmem_addr 0x100, wstrb F, wdata 0xDEADBEEF; rsp_valid in cycle 2 with rsp_we 0 and err 0.
2. SB addr 0x103, data 0x000000A5 -> wstrb 8, wdata 0xA5000000. LB addr 0x103 with rdata 0x80xxxxxx -> rsp_rdata 0xFFFFFF80. LBU at the same address -> 0x00000080.
3. LH addr 0x102 with rdata 0x8001xxxx, rd = 5 -> rsp_rdata 0xFFFF8001, rsp_rd 5, rsp_we 1. Repeat with rd = 0 -> rsp_we 0.
4. LW addr 0x101 -> no dmem_valid_o; rsp_valid in cycle 1 with err 1, code 01, rsp_we 0.
5. TIMEOUT_CYCLES = 4, ready held low -> dmem_valid_o high for 4 cycles, then rsp err code 10. Ready asserted in exactly the 4th cycle -> normal completion with no error.
6. XLEN = 64: LD addr 0x8 with rdata 0x0123456789ABCDEF -> same value, wstrb 00. SW addr 0x4 -> wstrb F0. LD with XLEN = 32 -> err code 11. Reset pulsed mid-ACCESS -> all outputs 0 and state IDLE.
